// File: rtl/mbo_pkg.sv
// Shared constants and types for the ADC sample path
// and the UDP frame reporter.
package mbo_pkg;

    localparam int ADC_WORD_W         = 16;
    localparam int FIFO_ADDR_W        = 10;
    localparam int FRAME_WORDS_PER_CH = 256;

    typedef logic [ADC_WORD_W-1:0] adc_word_t;

endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port RAM, registered read-first output, no reset.
// Maps onto a single block RAM.
module dp_ram_sync #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read-first: a read and write to the same slot returns the old word.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/adc_block_fifo.sv
// Per-channel circular sample buffer feeding the frame reporter;
// flags a ready block once THRESH words are held.
module adc_block_fifo
    import mbo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int THRESH = FRAME_WORDS_PER_CH,
    parameter int DATA_W = ADC_WORD_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sclr,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              rdreq,
    output logic [DATA_W-1:0] q,
    output logic              block_ready,
    output logic [ADDR_W:0]   usedw,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic [15:0]       drop_cnt
);

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   THR     = (ADDR_W+1)'(THRESH);
    localparam logic [ADDR_W:0]   ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   usedw_nxt;
    logic [DATA_W-1:0] ram_q;
    logic              q_vld;
    logic              rd_acc;
    logic              wr_acc;
    logic              ram_we;
    logic              ram_re;

    always_comb begin
        rd_acc    = rdreq & ~empty;
        wr_acc    = din_valid & (~full | rd_acc);
        ram_we    = wr_acc & ~sclr;
        ram_re    = rd_acc & ~sclr;
        usedw_nxt = usedw;
        if (wr_acc & ~rd_acc)
            usedw_nxt = usedw + ONE;
        else if (rd_acc & ~wr_acc)
            usedw_nxt = usedw - ONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            usedw       <= '0;
            q_vld       <= 1'b0;
            empty       <= 1'b1;
            full        <= 1'b0;
            block_ready <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            drop_cnt    <= '0;
        end else if (sclr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            usedw       <= '0;
            q_vld       <= 1'b0;
            empty       <= 1'b1;
            full        <= 1'b0;
            block_ready <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            if (rd_acc) q_vld  <= 1'b1;
            usedw       <= usedw_nxt;
            empty       <= (usedw_nxt == '0);
            full        <= (usedw_nxt == DEPTH);
            block_ready <= (usedw_nxt >= THR);
            if (din_valid & ~wr_acc) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
            if (rdreq & empty) underflow <= 1'b1;
        end
    end

    dp_ram_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // RAM output has no reset; mask it to zero until the first read after clear.
    assign q = q_vld ? ram_q : '0;

endmodule

// File: tb/tb_adc_block_fifo.sv
// Self-checking bench for adc_block_fifo: directed table,
// test-plan sequences and random traffic against a queue model.
module tb_adc_block_fifo;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sclr;
    logic [15:0] din;
    logic        din_valid;
    logic        rdreq;
    logic [15:0] q;
    logic        block_ready;
    logic [10:0] usedw;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    adc_block_fifo dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sclr        (sclr),
        .din         (din),
        .din_valid   (din_valid),
        .rdreq       (rdreq),
        .q           (q),
        .block_ready (block_ready),
        .usedw       (usedw),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow),
        .drop_cnt    (drop_cnt)
    );

    // Reference model: a plain queue of stored words plus sticky state.
    logic [15:0] mdl[$];
    logic [15:0] mq;
    bit          movf;
    bit          mudf;
    int          mdrop;

    task automatic model_reset();
        mdl.delete();
        mq    = '0;
        movf  = 0;
        mudf  = 0;
        mdrop = 0;
    endtask

    task automatic model_step(input bit dv, input logic [15:0] d,
                              input bit rd, input bit sc);
        int n;
        bit rda;
        bit wra;
        n = mdl.size();
        if (sc) begin
            model_reset();
        end else begin
            rda = rd && (n > 0);
            wra = dv && ((n < 1024) || rda);
            if (rda) mq = mdl.pop_front();
            if (wra) mdl.push_back(d);
            if (dv && !wra) begin
                movf = 1;
                if (mdrop < 65535) mdrop++;
            end
            if (rd && n == 0) mudf = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int n;
        n = mdl.size();
        chk("q", 32'(q), 32'(mq));
        chk("usedw", 32'(usedw), n);
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == 1024));
        chk("block_ready", 32'(block_ready), 32'(n >= 256));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("underflow", 32'(underflow), 32'(mudf));
        chk("drop_cnt", 32'(drop_cnt), mdrop);
    endtask

    task automatic cycle(input bit dv, input logic [15:0] d,
                         input bit rd, input bit sc);
        din_valid = dv;
        din       = d;
        rdreq     = rd;
        sclr      = sc;
        @(posedge clock);
        model_step(dv, d, rd, sc);
        #1;
        model_check();
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_q"}, 32'(q), 0);
        chk({nm, "_usedw"}, 32'(usedw), 0);
        chk({nm, "_empty"}, 32'(empty), 1);
        chk({nm, "_full"}, 32'(full), 0);
        chk({nm, "_br"}, 32'(block_ready), 0);
        chk({nm, "_ovf"}, 32'(overflow), 0);
        chk({nm, "_udf"}, 32'(underflow), 0);
        chk({nm, "_drop"}, 32'(drop_cnt), 0);
    endtask

    typedef struct {
        logic        dv;
        logic [15:0] din;
        logic        rd;
        logic        sc;
        logic [10:0] e_usedw;
        logic [15:0] e_q;
        logic        e_empty;
        logic        e_udf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] qh;
        logic [15:0] seq;
        int          pw;
        int          pr;

        tbl[0] = '{1'b1, 16'hA001, 1'b0, 1'b0, 11'd1, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'hA002, 1'b0, 1'b0, 11'd2, 16'h0000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 11'd1, 16'hA001, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 16'hA003, 1'b1, 1'b0, 11'd1, 16'hA002, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 11'd0, 16'hA003, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 11'd0, 16'hA003, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 16'hA004, 1'b1, 1'b0, 11'd1, 16'hA003, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 16'hA005, 1'b0, 1'b1, 11'd0, 16'h0000, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b1, 1'b1};

        reset_n   = 1'b0;
        sclr      = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        rdreq     = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].dv, tbl[i].din, tbl[i].rd, tbl[i].sc);
            chk($sformatf("tbl%0d_usedw", i), 32'(usedw), 32'(tbl[i].e_usedw));
            chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].e_q));
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_udf", i), 32'(underflow), 32'(tbl[i].e_udf));
        end

        cycle(0, 0, 0, 1);
        for (int i = 1; i < 256; i++) cycle(1, 16'(i), 0, 0);
        chk("thr_usedw255", 32'(usedw), 255);
        chk("thr_br_low", 32'(block_ready), 0);
        cycle(1, 16'h0100, 0, 0);
        chk("thr_br_high", 32'(block_ready), 1);

        for (int i = 0; i < 256; i++) begin
            cycle(0, 0, 1, 0);
            chk("cad_q", 32'(q), i + 1);
            if (i == 0) chk("cad_br_fall", 32'(block_ready), 0);
            repeat (7) cycle(0, 0, 0, 0);
        end
        chk("cad_empty", 32'(empty), 1);

        for (int i = 0; i < 1027; i++) cycle(1, 16'($urandom), 0, 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf", 32'(overflow), 1);
        chk("fill_drop", 32'(drop_cnt), 3);
        chk("fill_usedw", 32'(usedw), 1024);
        cycle(1, 16'hBEEF, 1, 0);
        chk("full_rw_usedw", 32'(usedw), 1024);

        for (int i = 0; i < 1024; i++) cycle(0, 0, 1, 0);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_last_q", 32'(q), 32'h0000BEEF);
        qh = q;
        cycle(0, 0, 1, 0);
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_q_hold", 32'(q), 32'(qh));
        chk("udf_usedw", 32'(usedw), 0);
        cycle(1, 16'h5A5A, 1, 0);
        chk("udf_wr_usedw", 32'(usedw), 1);
        chk("udf_wr_q_hold", 32'(q), 32'(qh));

        cycle(0, 0, 0, 1);
        seq = 16'h1000;
        for (int i = 0; i < 10; i++) begin
            cycle(1, seq, 0, 0);
            seq++;
        end
        for (int i = 0; i < 3000; i++) begin
            cycle(1, seq, 1, 0);
            chk("stream_q", 32'(q), 32'(16'(seq - 16'd10)));
            seq++;
        end
        chk("stream_usedw", 32'(usedw), 10);

        for (int blk = 0; blk < 8; blk++) begin
            pw = (blk % 2 == 0) ? 85 : 15;
            pr = (blk % 2 == 0) ? 15 : 85;
            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(0, 99) < pw, 16'($urandom),
                      $urandom_range(0, 99) < pr, $urandom_range(0, 499) == 0);
            end
        end

        cycle(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) cycle(1, 16'($urandom), 0, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 16'h1234, 0, 0);
        chk("pre_rst_usedw", 32'(usedw), 300);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) cycle(1, 16'($urandom), 0, 0);
        chk("pre_sclr_usedw", 32'(usedw), 5);
        cycle(1, 16'h7777, 0, 1);
        chk("sclr_wr_usedw", 32'(usedw), 0);
        chk("sclr_wr_empty", 32'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_block_fifo.md
Name: adc_block_fifo

Overview:
- Per-channel sample buffer directly upstream of the UDP frame reporter. One instance per ADC channel; two instances feed the reporter's `data_blocks1/2` inputs.
- Accepts 16-bit words from the acquisition path and stores them in a circular buffer.
- Raises `block_ready` while at least `THRESH` words (one frame payload share) are held.
- Returns words on `rdreq` with fixed one-cycle read latency (normal, non-show-ahead mode), as the reporter's nibble sequencer expects.

Parameters:
- ADDR_W, 10, address width; depth = 2**ADDR_W words (1024).
- THRESH, 256, `usedw` level at or above which `block_ready` is asserted.
- DATA_W, 16, word width.

Ports:
- clock  in  1  system clock (125 MHz domain of the reporter).
- reset_n  in  1  asynchronous, active-low reset.
- sclr  in  1  synchronous clear, active high; same effect as reset except memory contents.
- din  in  DATA_W  sample word from acquisition path.
- din_valid  in  1  write strobe, one word per cycle when high.
- rdreq  in  1  read request from reporter, one word per cycle when high.
- q  out  DATA_W  read data, registered.
- block_ready  out  1  high while usedw >= THRESH (drives reporter `is_there_256_x`).
- usedw  out  ADDR_W+1  words currently stored, 0..2**ADDR_W.
- empty  out  1  usedw == 0.
- full  out  1  usedw == 2**ADDR_W.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: rdreq arrived while empty.
- drop_cnt  out  16  count of dropped writes, saturating at 16'hFFFF.

Behaviour:
- Reset (async, reset_n low) or sclr high at an edge:
  - wr_ptr and rd_ptr = 0, usedw = 0, q = 0, block_ready = 0, empty = 1, full = 0, overflow = 0, underflow = 0, drop_cnt = 0.
  - RAM contents are not cleared.
  - sclr has priority over din_valid and rdreq in the same cycle.
- Write accept: wr_acc = din_valid & (~full | rd_acc). Accepted: RAM[wr_ptr] <= din, wr_ptr += 1, wrapping modulo 2**ADDR_W.
- Read accept: rd_acc = rdreq & ~empty. Accepted: q <= RAM[rd_ptr] at that edge, so data is visible the cycle after rdreq is sampled; rd_ptr += 1 with wrap. Without rd_acc, q holds its value.
- usedw: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither. Updated at the same edge as the pointers.
- empty, full and block_ready are registered from the next usedw value, so all flags change at the same edge as usedw. block_ready therefore rises at the edge that accepts the THRESH-th word.
- Full boundary:
  - din_valid & full & ~rdreq: word dropped; overflow <= 1; drop_cnt += 1 (saturating).
  - din_valid & full & rdreq: both accepted; usedw stays 2**ADDR_W.
- Empty boundary:
  - rdreq & empty: no pointer change; q holds; underflow <= 1.
  - din_valid & rdreq & empty: write accepted, read rejected (no write-through bypass); underflow <= 1.
- Sticky flags (overflow, underflow) clear only on reset or sclr.
- Pointer wrap: pointers are ADDR_W bits; full/empty come from usedw, not from pointer compare.
- Reset mid-frame: outstanding reporter read is abandoned; q returns to 0 immediately (async). Upstream must re-establish frame alignment.
- No combinational path from any input to any output.

Decomposition:
- Shared package mbo_pkg:
  - constants ADC_WORD_W = 16, FIFO_ADDR_W = 10, FRAME_WORDS_PER_CH = 256;
  - typedef adc_word_t (logic [15:0]).
  - The reporter and both FIFO instances use these constants.
- One sub-module, dp_ram_sync: simple dual-port RAM, 2**ADDR_W x DATA_W, registered read port, no reset, inferable as block RAM. Pointer, usedw, flag and counter logic stays in adc_block_fifo.

Test Plan:
- Reset, then write 255 words 0x0001..0x00FF: usedw = 255, block_ready = 0. Write 0x0100: block_ready = 1 at the edge that accepts it.
- Read 256 words with rdreq pulsed one cycle in every 8 (reporter cadence): each q appears one cycle after its rdreq, values 0x0001..0x0100 in order. block_ready falls after the first read; empty = 1 after the last.
- Fill to 1024, then 3 more writes without rdreq: full = 1, overflow = 1, drop_cnt = 3, usedw = 1024. Next write with rdreq high is accepted and usedw stays 1024.
- rdreq on empty FIFO: underflow = 1, q unchanged, usedw = 0. Same-cycle din_valid + rdreq on empty: usedw = 1, underflow = 1.
- Continuous write + read across 3000 words: pointer wrap is seamless, read data equals written sequence, usedw stays constant.
- With usedw = 300, assert reset_n low asynchronously mid-cycle: all outputs return to reset values immediately. sclr with a simultaneous write: usedw = 0 after the edge.
